// File: rtl/bsg_cgol_pkg.sv
// Shared definitions for the Game-of-Life controller: FSM state codes and
// the width helper for the generation-count field.
package bsg_cgol_pkg;

    typedef logic [1:0] cgol_state_t;

    localparam cgol_state_t eWAIT = 2'd0;
    localparam cgol_state_t eLOAD = 2'd1;
    localparam cgol_state_t eBUSY = 2'd2;
    localparam cgol_state_t eDONE = 2'd3;

    function automatic int cgol_len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/bsg_cgol_frame_counter.sv
// Loadable down-counter for the remaining generations; the load value is
// clamped to max_val_p and decrementing stops at zero.
module bsg_cgol_frame_counter
    import bsg_cgol_pkg::*;
#(
    parameter int max_val_p = 10,
    parameter int width_p   = cgol_len_width(max_val_p)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               load_i,
    input  logic [width_p-1:0] load_val_i,
    input  logic               dec_i,
    output logic               zero_o,
    output logic               one_o
);

    localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

    logic [width_p-1:0] count_q, count_d;
    logic [width_p-1:0] load_sat;

    assign load_sat = (load_val_i > max_lp) ? max_lp : load_val_i;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_sat;
        end else if (dec_i && !zero_o) begin
            count_d = count_q - width_p'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);
    assign one_o  = (count_q == width_p'(1));

endmodule

// File: rtl/bsg_cgol_ctrl.sv
// Game-of-Life controller: accepts a board and generation count, loads the
// cell array, steps it the requested number of times, then offers the result.
module bsg_cgol_ctrl
    import bsg_cgol_pkg::*;
#(
    parameter int board_width_p     = 8,
    parameter int max_game_length_p = 10,
    localparam int cells_lp         = board_width_p * board_width_p,
    localparam int len_width_lp     = cgol_len_width(max_game_length_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic                    v_i,
    output logic                    ready_o,
    input  logic [cells_lp-1:0]     data_i,
    input  logic [len_width_lp-1:0] frames_i,

    output logic                    update_o,
    output logic [cells_lp-1:0]     update_val_o,
    output logic                    en_o,
    input  logic [cells_lp-1:0]     cells_data_i,

    output logic                    v_o,
    output logic [cells_lp-1:0]     data_o,
    input  logic                    yumi_i
);

    cgol_state_t         state_q, state_d;
    logic [cells_lp-1:0] board_q, board_d;
    logic                cnt_load, cnt_dec, cnt_zero, cnt_one;

    bsg_cgol_frame_counter #(
        .max_val_p (max_game_length_p),
        .width_p   (len_width_lp)
    ) frame_counter (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_i     (cnt_load),
        .load_val_i (frames_i),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero),
        .one_o      (cnt_one)
    );

    // The counter holds the generations still to run; eBUSY leaves on the
    // last one so en_o is asserted exactly once per remaining generation.
    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            eWAIT: begin
                if (v_i) begin
                    board_d  = data_i;
                    cnt_load = 1'b1;
                    state_d  = eLOAD;
                end
            end
            eLOAD: begin
                state_d = cnt_zero ? eDONE : eBUSY;
            end
            eBUSY: begin
                cnt_dec = 1'b1;
                if (cnt_one) begin
                    state_d = eDONE;
                end
            end
            eDONE: begin
                if (yumi_i) begin
                    state_d = eWAIT;
                end
            end
            default: begin
                state_d = eWAIT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= eWAIT;
            board_q <= '0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
        end
    end

    assign ready_o      = (state_q == eWAIT);
    assign update_o     = (state_q == eLOAD);
    assign en_o         = (state_q == eBUSY);
    assign v_o          = (state_q == eDONE);
    assign update_val_o = board_q;
    assign data_o       = cells_data_i;

endmodule

// File: doc/bsg_cgol_ctrl.md
BSG_CGOL_CTRL -- requirements
Module: bsg_cgol_ctrl

Interface
REQ-001 The block SHALL have parameter board_width_p, default 8, giving the board edge length; the board holds board_width_p*board_width_p cells, called B bits.
REQ-002 The block SHALL have parameter max_game_length_p, default 10, giving the maximum number of generations per game.
REQ-003 The generation-count field width L SHALL be $clog2(max_game_length_p+1).
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n_i  input  1  reset, asynchronous, active-low.
REQ-006 v_i  input  1  new game request valid.
REQ-007 ready_o  output  1  controller can accept a game.
REQ-008 data_i  input  B  initial board, bit r*board_width_p+c for row r, column c.
REQ-009 frames_i  input  L  number of generations to simulate.
REQ-010 update_o  output  1  load strobe to the cell array.
REQ-011 update_val_o  output  B  per-cell load values.
REQ-012 en_o  output  1  generation-step enable to the cell array.
REQ-013 cells_data_i  input  B  current cell array state.
REQ-014 v_o  output  1  final board valid.
REQ-015 data_o  output  B  final board.
REQ-016 yumi_i  input  1  consumer takes data_o; legal only while v_o=1.

Function
REQ-017 The FSM SHALL have exactly four states: eWAIT, eLOAD, eBUSY and eDONE.
REQ-018 In eWAIT: ready_o=1; on v_i=1, board_r<=data_i and count_r<=min(frames_i, max_game_length_p); next state eLOAD.
REQ-019 In eLOAD: update_o=1 and update_val_o=board_r for exactly one cycle; next state is eDONE if count_r==0, else eBUSY.
REQ-020 In eBUSY: en_o=1 every cycle and count_r decrements each cycle; when count_r==1, next state is eDONE.
REQ-021 As a result of REQ-020, en_o SHALL be high for exactly count_r consecutive cycles per game.
REQ-022 In eDONE: v_o=1 and data_o=cells_data_i (combinational); on yumi_i=1, next state is eWAIT.
REQ-023 Outside their own state, ready_o, update_o, en_o and v_o SHALL be 0.
REQ-024 update_o and en_o SHALL never be high in the same cycle.
REQ-025 update_val_o SHALL equal board_r in all states.
REQ-026 Latency: handshake at edge T gives update_o in cycle T+1, en_o in cycles T+2..T+1+N, and v_o from cycle T+2+N, where N is the saturated count.
REQ-027 With N=0, v_o SHALL rise in cycle T+2 with data_o equal to the loaded board.
REQ-028 frames_i > max_game_length_p SHALL saturate to max_game_length_p; no wrap-around.
REQ-029 v_i SHALL be ignored outside eWAIT; no request is queued.
REQ-030 Held yumi_i=0 in eDONE SHALL keep v_o=1, en_o=0, and the board stable indefinitely.
REQ-031 Back-to-back games: with yumi_i in cycle X, ready_o=1 in cycle X+1.

Reset
REQ-032 reset_n_i=0 SHALL asynchronously force state=eWAIT, count_r=0 and board_r=0.
REQ-033 During reset: ready_o=1, update_o=0, en_o=0 and v_o=0.
REQ-034 Reset asserted mid-eBUSY or mid-eDONE SHALL abort the game with no further en_o pulses.
REQ-035 The cell array is not cleared by this block.

Structure
REQ-036 The state enum and the L width function SHALL live in shared package bsg_cgol_pkg.
REQ-037 One sub-module SHALL be used: bsg_cgol_frame_counter, a loadable saturating down-counter with a zero/one flag.
REQ-038 The remaining logic is the FSM and board_r register, about 150-250 lines in total.

Verification
REQ-039 All scenarios SHALL use board_width_p=4 and max_game_length_p=10 with a 4x4 cell array in the bench.
REQ-040 Vertical blinker (bits 1,5,9 set), frames_i=1 -> data_o has bits 4,5,6 set; exactly 1 en_o cycle.
REQ-041 Same blinker, frames_i=2 -> data_o equals the input board (bits 1,5,9).
REQ-042 frames_i=0, board 0xA5A5 -> no en_o; v_o in cycle T+2; data_o=0xA5A5.
REQ-043 frames_i=15 -> exactly 10 en_o cycles (saturation).
REQ-044 yumi_i held 0 for 5 cycles in eDONE -> v_o stays 1, ready_o=0, data_o stable; v_i pulses are ignored.
REQ-045 reset_n_i low during the 3rd en_o cycle of frames_i=8 -> en_o=0 immediately; after release, ready_o=1 and the next game runs normally.
